// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and default frame/oversampling parameters,
// used by the receiver, the transmitter and the baud rate generator.
package uart_pkg;

    localparam int DEFAULT_DATA_BITS  = 8;
    localparam int DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Serial line synchroniser with armed falling-edge (start) detection.
// The detector re-arms only after the line has been seen high on a baud tick.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic baud_tick,
    input  logic rx_in,
    input  logic disarm,
    output logic rxs,
    output logic start_det
);

    logic meta;
    logic armed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b1;
            rxs  <= 1'b1;
        end else begin
            meta <= rx_in;
            rxs  <= meta;
        end
    end

    // disarm wins over re-arming so a frame end never counts as having seen the line high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed <= 1'b1;
        end else if (disarm) begin
            armed <= 1'b0;
        end else if (baud_tick && rxs) begin
            armed <= 1'b1;
        end
    end

    assign start_det = baud_tick && armed && !rxs;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, LSB first, 1-clk valid/error pulses.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
//   state  | meaning
//   IDLE   | waiting for an armed falling edge
//   START  | confirming start bit at its middle
//   DATA   | sampling DATA_BITS data bits
//   PARITY | sampling parity bit (UART_RX_PARITY_EN only)
//   STOP   | sampling stop bit, issuing result pulse
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx_in,
    input  logic                 parity_odd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    uart_state_t          state, state_n;
    logic [TW-1:0]        tick_cnt, tick_n;
    logic [BW-1:0]        bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shreg, shreg_n, data_n;
    logic                 valid_n, ferr_n;
    logic                 disarm;
    logic                 rxs, start_det;
`ifdef UART_RX_PARITY_EN
    logic                 perr, perr_n, perr_out_n;
`endif

    uart_rx_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .rx_in     (rx_in),
        .disarm    (disarm),
        .rxs       (rxs),
        .start_det (start_det)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            tick_cnt  <= tick_n;
            bit_cnt   <= bit_n;
            shreg     <= shreg_n;
            rx_data   <= data_n;
            rx_valid  <= valid_n;
            frame_err <= ferr_n;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perr       <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            perr       <= perr_n;
            parity_err <= perr_out_n;
        end
    end
`else
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
    assign parity_err        = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        tick_n   = tick_cnt;
        bit_n    = bit_cnt;
        shreg_n  = shreg;
        data_n   = rx_data;
        valid_n  = 1'b0;
        ferr_n   = 1'b0;
        disarm   = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_n     = perr;
        perr_out_n = 1'b0;
`endif
        if (baud_tick) begin
            case (state)
                ST_IDLE: begin
                    if (start_det) begin
                        state_n = ST_START;
                        tick_n  = '0;
                    end
                end
                ST_START: begin
                    if (tick_cnt == TICK_MID) begin
                        tick_n = '0;
                        bit_n  = '0;
                        state_n = rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_n  = '0;
                        bit_n   = bit_cnt + 1'b1;
                        shreg_n = {rxs, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_n = ST_PARITY;
`else
                            state_n = ST_STOP;
`endif
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_n  = '0;
                        perr_n  = rxs ^ (^shreg) ^ parity_odd;
                        state_n = ST_STOP;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_n  = '0;
                        disarm  = 1'b1;
                        state_n = ST_IDLE;
                        if (rxs) begin
                            data_n  = shreg;
                            valid_n = 1'b1;
`ifdef UART_RX_PARITY_EN
                            perr_out_n = perr;
`endif
                        end else begin
                            ferr_n = 1'b1;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    tick_n  = '0;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames, expected pulses queued by stimulus,
// popped and compared by an independent monitor.
module tb_uart_rx;

    localparam int BIT_CLKS = 64;

    logic       clk        = 1'b0;
    logic       rst        = 1'b0;
    logic       baud_tick  = 1'b0;
    logic       rx_in      = 1'b1;
    logic       parity_odd = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err, busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       ferr;
        logic [7:0] data;
        logic       perr;
    } exp_t;

    exp_t exp_q[$];

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_tick  (baud_tick),
        .rx_in      (rx_in),
        .parity_odd (parity_odd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin : tick_gen
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            baud_tick = (c == 0);
            c = (c + 1) % 4;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par_b);
`endif
        send_bit(stop_b);
    endtask

    task automatic expect_data(input logic [7:0] d, input logic perr);
        exp_t e;
        e.ferr = 1'b0;
        e.data = d;
`ifdef UART_RX_PARITY_EN
        e.perr = perr;
`else
        e.perr = 1'b0;
`endif
        exp_q.push_back(e);
    endtask

    task automatic expect_ferr();
        exp_t e;
        e.ferr = 1'b1;
        e.data = 8'h00;
        e.perr = 1'b0;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rx_valid || frame_err || parity_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {29'd0, rx_valid, frame_err, parity_err}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_valid", rx_valid, !e.ferr);
                    check("frame_err", frame_err, e.ferr);
                    check("parity_err", parity_err, e.perr);
                    if (!e.ferr) check("rx_data", rx_data, e.data);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        // reset state
        repeat (3) @(negedge clk);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_parity_err", parity_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);

        // 1: clean frame
        expect_data(8'hA5, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0);
        check("t1_busy_drop", busy, 1'b0);
        check("t1_rx_data", rx_data, 8'hA5);
        repeat (BIT_CLKS) @(negedge clk);

        // 2: start glitch of 4 ticks
        rx_in = 1'b0;
        repeat (12) @(negedge clk);
        check("t2_busy_high", busy, 1'b1);
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        check("t2_busy_idle", busy, 1'b0);
        check("t2_rx_data", rx_data, 8'hA5);

        // 3: framing error, break, then recovery
        expect_ferr();
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (20 * BIT_CLKS) @(negedge clk);
        check("t3_break_busy", busy, 1'b0);
        check("t3_rx_data_held", rx_data, 8'hA5);
        rx_in = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        expect_data(8'h11, 1'b0);
        send_frame(8'h11, 1'b1, 1'b0);
        check("t3_rx_data", rx_data, 8'h11);
        repeat (BIT_CLKS) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        // 4: even parity; 0x07 has three ones
        parity_odd = 1'b0;
        expect_data(8'h07, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1);
        expect_data(8'h07, 1'b1);
        send_frame(8'h07, 1'b1, 1'b0);
        repeat (BIT_CLKS) @(negedge clk);
`endif

        // 5: reset during data bit 4
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx_in = 1'b1;
        repeat (BIT_CLKS / 2) @(negedge clk);
        check("t5_busy_before", busy, 1'b1);
        rst = 1'b0;
        #1;
        check("t5_rx_data", rx_data, 8'h00);
        check("t5_rx_valid", rx_valid, 1'b0);
        check("t5_frame_err", frame_err, 1'b0);
        check("t5_parity_err", parity_err, 1'b0);
        check("t5_busy", busy, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (6 * BIT_CLKS) @(negedge clk);
        check("t5_no_resume", busy, 1'b0);
        expect_data(8'h5A, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b0);
        check("t5_rx_data_after", rx_data, 8'h5A);

        // 6: back-to-back frames, no idle gap
        expect_data(8'h00, 1'b0);
        expect_data(8'hFF, 1'b0);
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        check("t6_rx_data", rx_data, 8'hFF);
        repeat (2 * BIT_CLKS) @(negedge clk);

        check("pending_pulses", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
